// File: rtl/store_unit_pkg.sv
// Shared store-op encodings, FSM states and strobe helper for the store unit.
// Op values mirror the load-side constants so both paths decode req_op identically.
package store_unit_pkg;

  localparam logic [1:0] C_MEMSTORE_BYTE = 2'd0;
  localparam logic [1:0] C_MEMSTORE_HALF = 2'd1;
  localparam logic [1:0] C_MEMSTORE_WORD = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BEAT0 = 3'd1,
    ST_BEAT1 = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } store_state_t;

  // Unshifted strobe pattern for an access size; undefined ops fall through to WORD.
  function automatic logic [3:0] baseStrobe(input logic [1:0] op);
    logic [3:0] strb;
    case (op)
      C_MEMSTORE_BYTE: strb = 4'b0001;
      C_MEMSTORE_HALF: strb = 4'b0011;
      C_MEMSTORE_WORD: strb = 4'b1111;
      default:         strb = 4'b1111;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/store_unit_align.sv
// Combinational lane aligner: places size-masked store data and strobes onto a
// 64-bit (two-word) window so the upper half directly forms the second beat.
module store_unit_align
  import store_unit_pkg::*;
(
  input  logic [1:0]  i_off,
  input  logic [31:0] i_data,
  input  logic [1:0]  i_op,
  output logic [63:0] o_d64,
  output logic [7:0]  o_s8
);

  logic [31:0] w_masked;
  logic [5:0]  w_shift;

  always_comb begin
    w_masked = i_data;
    case (i_op)
      C_MEMSTORE_BYTE: w_masked = {24'd0, i_data[7:0]};
      C_MEMSTORE_HALF: w_masked = {16'd0, i_data[15:0]};
      default:         w_masked = i_data;
    endcase
  end

  assign w_shift = {1'b0, i_off, 3'b000};
  assign o_d64   = {32'd0, w_masked} << w_shift;
  assign o_s8    = {4'd0, baseStrobe(i_op)} << i_off;

endmodule

// File: rtl/store_unit.sv
// Write-side memory stage: accepts one store, emits one or two word-aligned
// write beats with byte strobes, then pulses done (or err when splitting is disabled).
module store_unit
  import store_unit_pkg::*;
#(
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [1:0]  req_op,
  output logic        mem_wvalid,
  input  logic        mem_wready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  output logic        done,
  output logic        err
);

  store_state_t r_state, w_nextState;

  logic        r_ready, r_wvalid, r_done, r_err;
  logic [31:0] r_memAddr, r_memData;
  logic [3:0]  r_memStrb;
  logic [31:0] r_hiAddr, r_hiData;
  logic [3:0]  r_hiStrb;

  logic [31:0] w_nextAddr, w_nextData;
  logic [3:0]  w_nextStrb;
  logic        w_loadHi;
  logic [63:0] w_d64;
  logic [7:0]  w_s8;
  logic        w_split;
  logic        w_hiPending;
  logic [31:0] w_beat0Addr;

  store_unit_align u_align (
    .i_off  (req_addr[1:0]),
    .i_data (req_data),
    .i_op   (req_op),
    .o_d64  (w_d64),
    .o_s8   (w_s8)
  );

  assign w_split     = (w_s8[7:4] != 4'd0);
  assign w_hiPending = (r_hiStrb != 4'd0);
  assign w_beat0Addr = {req_addr[31:2], 2'b00};

  // Next state plus next values of the registered beat outputs; beat fields hold while stalled.
  always_comb begin
    w_nextState = r_state;
    w_nextAddr  = r_memAddr;
    w_nextData  = r_memData;
    w_nextStrb  = r_memStrb;
    w_loadHi    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          if (w_split && !SPLIT_MISALIGNED) begin
            w_nextState = ST_ERR;
          end else begin
            w_nextState = ST_BEAT0;
            w_nextAddr  = w_beat0Addr;
            w_nextData  = w_d64[31:0];
            w_nextStrb  = w_s8[3:0];
            w_loadHi    = 1'b1;
          end
        end
      end
      ST_BEAT0: begin
        if (mem_wready) begin
          if (w_hiPending) begin
            w_nextState = ST_BEAT1;
            w_nextAddr  = r_hiAddr;
            w_nextData  = r_hiData;
            w_nextStrb  = r_hiStrb;
          end else begin
            w_nextState = ST_DONE;
            w_nextAddr  = 32'd0;
            w_nextData  = 32'd0;
            w_nextStrb  = 4'd0;
          end
        end
      end
      ST_BEAT1: begin
        if (mem_wready) begin
          w_nextState = ST_DONE;
          w_nextAddr  = 32'd0;
          w_nextData  = 32'd0;
          w_nextStrb  = 4'd0;
        end
      end
      ST_DONE: w_nextState = ST_IDLE;
      ST_ERR:  w_nextState = ST_IDLE;
      default: begin
        w_nextState = ST_IDLE;
        w_nextAddr  = 32'd0;
        w_nextData  = 32'd0;
        w_nextStrb  = 4'd0;
      end
    endcase
  end

  // Handshake flags are derived from the next state so every output leaves a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_ready   <= 1'b1;
      r_wvalid  <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_memAddr <= 32'd0;
      r_memData <= 32'd0;
      r_memStrb <= 4'd0;
    end else begin
      r_state   <= w_nextState;
      r_ready   <= (w_nextState == ST_IDLE);
      r_wvalid  <= (w_nextState == ST_BEAT0) || (w_nextState == ST_BEAT1);
      r_done    <= (w_nextState == ST_DONE);
      r_err     <= (w_nextState == ST_ERR);
      r_memAddr <= w_nextAddr;
      r_memData <= w_nextData;
      r_memStrb <= w_nextStrb;
    end
  end

  // Second-beat payload is captured at accept; the address wraps modulo 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hiAddr <= 32'd0;
      r_hiData <= 32'd0;
      r_hiStrb <= 4'd0;
    end else if (w_loadHi) begin
      r_hiAddr <= w_beat0Addr + 32'd4;
      r_hiData <= w_d64[63:32];
      r_hiStrb <= w_s8[7:4];
    end
  end

  assign req_ready  = r_ready;
  assign mem_wvalid = r_wvalid;
  assign mem_addr   = r_memAddr;
  assign mem_wdata  = r_memData;
  assign mem_wstrb  = r_memStrb;
  assign done       = r_done;
  assign err        = r_err;

endmodule

// File: tb/tb_store_unit.sv
// Directed bench for store_unit: lane alignment, split beats, stall, reset abort,
// and rejection on a second instance built with splitting disabled.
module tb_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [31:0] req_addr, req_data;
  logic [1:0]  req_op;
  logic        mem_wvalid, mem_wready;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        done, err;

  logic        req_valid2, req_ready2;
  logic [31:0] req_addr2, req_data2;
  logic [1:0]  req_op2;
  logic        mem_wvalid2;
  logic [31:0] mem_addr2, mem_wdata2;
  logic [3:0]  mem_wstrb2;
  logic        done2, err2;
  logic        sawWvalid2;

  int checks;
  int failures;

  store_unit #(.SPLIT_MISALIGNED(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_op(req_op),
    .mem_wvalid(mem_wvalid), .mem_wready(mem_wready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .done(done), .err(err)
  );

  store_unit #(.SPLIT_MISALIGNED(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_addr(req_addr2), .req_data(req_data2), .req_op(req_op2),
    .mem_wvalid(mem_wvalid2), .mem_wready(1'b1), .mem_addr(mem_addr2),
    .mem_wdata(mem_wdata2), .mem_wstrb(mem_wstrb2), .done(done2), .err(err2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_wvalid2) sawWvalid2 <= 1'b1;

  // Presents one request for a single clock edge; returns at the following negedge.
  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [1:0] op);
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    req_op    = op;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks++;
    if ({req_ready, mem_wvalid, done, err} !== 4'b1000) begin
      failures++;
      $display("[TB] FAIL reset_flags got=%b exp=1000", {req_ready, mem_wvalid, done, err});
    end
    checks++;
    if ({mem_addr, mem_wdata, mem_wstrb} !== 68'd0) begin
      failures++;
      $display("[TB] FAIL reset_beat got=%h/%h/%b exp=0", mem_addr, mem_wdata, mem_wstrb);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_byte;
    issue(32'h0000_1003, 32'h0000_00AB, 2'd0);
    checks++;
    if ({mem_wvalid, mem_addr, mem_wdata, mem_wstrb} !== {1'b1, 32'h0000_1000, 32'hAB00_0000, 4'b1000}) begin
      failures++;
      $display("[TB] FAIL byte_beat got=%b %h %h %b exp=1 00001000 ab000000 1000", mem_wvalid, mem_addr, mem_wdata, mem_wstrb);
    end
    checks++;
    if ({req_ready, done} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL byte_busy got=%b exp=00", {req_ready, done});
    end
    @(negedge clk);
    checks++;
    if ({mem_wvalid, done, req_ready} !== 3'b010) begin
      failures++;
      $display("[TB] FAIL byte_done got=%b exp=010", {mem_wvalid, done, req_ready});
    end
    @(negedge clk);
    checks++;
    if ({done, req_ready} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL byte_idle got=%b exp=01", {done, req_ready});
    end
  endtask

  task automatic test_half;
    issue(32'h0000_2002, 32'hFFFF_1234, 2'd1);
    checks++;
    if ({mem_wvalid, mem_addr, mem_wdata, mem_wstrb} !== {1'b1, 32'h0000_2000, 32'h1234_0000, 4'b1100}) begin
      failures++;
      $display("[TB] FAIL half_beat got=%b %h %h %b exp=1 00002000 12340000 1100", mem_wvalid, mem_addr, mem_wdata, mem_wstrb);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("[TB] FAIL half_done got=%b exp=1", done);
    end
    @(negedge clk);
  endtask

  task automatic test_undef_op;
    issue(32'h0000_0010, 32'hCAFE_BABE, 2'd3);
    checks++;
    if ({mem_addr, mem_wdata, mem_wstrb} !== {32'h0000_0010, 32'hCAFE_BABE, 4'b1111}) begin
      failures++;
      $display("[TB] FAIL undef_op got=%h %h %b exp=00000010 cafebabe 1111", mem_addr, mem_wdata, mem_wstrb);
    end
    @(negedge clk);
    checks++;
    if ({mem_wvalid, done} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL undef_done got=%b exp=01", {mem_wvalid, done});
    end
    @(negedge clk);
  endtask

  task automatic test_split_word;
    issue(32'h0000_3001, 32'hDDCC_BBAA, 2'd2);
    checks++;
    if ({mem_wvalid, mem_addr, mem_wdata, mem_wstrb} !== {1'b1, 32'h0000_3000, 32'hCCBB_AA00, 4'b1110}) begin
      failures++;
      $display("[TB] FAIL split_beat0 got=%b %h %h %b exp=1 00003000 ccbbaa00 1110", mem_wvalid, mem_addr, mem_wdata, mem_wstrb);
    end
    @(negedge clk);
    checks++;
    if ({mem_wvalid, mem_addr, mem_wdata, mem_wstrb, done} !== {1'b1, 32'h0000_3004, 32'h0000_00DD, 4'b0001, 1'b0}) begin
      failures++;
      $display("[TB] FAIL split_beat1 got=%b %h %h %b done=%b exp=1 00003004 000000dd 0001 done=0", mem_wvalid, mem_addr, mem_wdata, mem_wstrb, done);
    end
    @(negedge clk);
    checks++;
    if ({mem_wvalid, done, req_ready} !== 3'b010) begin
      failures++;
      $display("[TB] FAIL split_done got=%b exp=010", {mem_wvalid, done, req_ready});
    end
    @(negedge clk);
    checks++;
    if ({done, req_ready} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL split_idle got=%b exp=01", {done, req_ready});
    end
  endtask

  task automatic test_split_half;
    issue(32'h0000_0103, 32'h0000_BEEF, 2'd1);
    checks++;
    if ({mem_addr, mem_wdata, mem_wstrb} !== {32'h0000_0100, 32'hEF00_0000, 4'b1000}) begin
      failures++;
      $display("[TB] FAIL half3_beat0 got=%h %h %b exp=00000100 ef000000 1000", mem_addr, mem_wdata, mem_wstrb);
    end
    @(negedge clk);
    checks++;
    if ({mem_wvalid, mem_addr, mem_wdata, mem_wstrb} !== {1'b1, 32'h0000_0104, 32'h0000_00BE, 4'b0001}) begin
      failures++;
      $display("[TB] FAIL half3_beat1 got=%b %h %h %b exp=1 00000104 000000be 0001", mem_wvalid, mem_addr, mem_wdata, mem_wstrb);
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_wrap;
    issue(32'hFFFF_FFFE, 32'h1122_3344, 2'd2);
    checks++;
    if ({mem_addr, mem_wdata, mem_wstrb} !== {32'hFFFF_FFFC, 32'h3344_0000, 4'b1100}) begin
      failures++;
      $display("[TB] FAIL wrap_beat0 got=%h %h %b exp=fffffffc 33440000 1100", mem_addr, mem_wdata, mem_wstrb);
    end
    @(negedge clk);
    checks++;
    if ({mem_wvalid, mem_addr, mem_wdata, mem_wstrb} !== {1'b1, 32'h0000_0000, 32'h0000_1122, 4'b0011}) begin
      failures++;
      $display("[TB] FAIL wrap_beat1 got=%b %h %h %b exp=1 00000000 00001122 0011", mem_wvalid, mem_addr, mem_wdata, mem_wstrb);
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_stall;
    mem_wready = 1'b0;
    issue(32'h0000_3001, 32'hDDCC_BBAA, 2'd2);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({mem_wvalid, mem_addr, mem_wdata, mem_wstrb, req_ready, done} !== {1'b1, 32'h0000_3000, 32'hCCBB_AA00, 4'b1110, 1'b0, 1'b0}) begin
        failures++;
        $display("[TB] FAIL stall_hold[%0d] got=%b %h %h %b rdy=%b done=%b exp=1 00003000 ccbbaa00 1110 rdy=0 done=0", i, mem_wvalid, mem_addr, mem_wdata, mem_wstrb, req_ready, done);
      end
      @(negedge clk);
    end
    mem_wready = 1'b1;
    checks++;
    if (mem_addr !== 32'h0000_3000) begin
      failures++;
      $display("[TB] FAIL stall_last got=%h exp=00003000", mem_addr);
    end
    @(negedge clk);
    checks++;
    if ({mem_addr, mem_wstrb} !== {32'h0000_3004, 4'b0001}) begin
      failures++;
      $display("[TB] FAIL stall_beat1 got=%h %b exp=00003004 0001", mem_addr, mem_wstrb);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("[TB] FAIL stall_done got=%b exp=1", done);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic sawDone;
    issue(32'h0000_3001, 32'hDDCC_BBAA, 2'd2);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_wvalid, req_ready, done} !== 3'b010) begin
      failures++;
      $display("[TB] FAIL rstmid_now got=%b exp=010", {mem_wvalid, req_ready, done});
    end
    @(negedge clk);
    rst_n = 1'b1;
    sawDone = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done || mem_wvalid) sawDone = 1'b1;
    end
    checks++;
    if ({sawDone, req_ready} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL rstmid_after got=%b exp=01", {sawDone, req_ready});
    end
  endtask

  task automatic test_reject;
    @(negedge clk);
    req_valid2 = 1'b1;
    req_addr2  = 32'h0000_0002;
    req_data2  = 32'h1234_5678;
    req_op2    = 2'd2;
    @(negedge clk);
    req_valid2 = 1'b0;
    checks++;
    if ({err2, mem_wvalid2, req_ready2, done2} !== 4'b1000) begin
      failures++;
      $display("[TB] FAIL reject_err got=%b exp=1000", {err2, mem_wvalid2, req_ready2, done2});
    end
    @(negedge clk);
    checks++;
    if ({err2, req_ready2} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL reject_idle got=%b exp=01", {err2, req_ready2});
    end
    @(negedge clk);
    checks++;
    if (sawWvalid2 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reject_nowrite got=%b exp=0", sawWvalid2);
    end
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    req_valid = 1'b0; req_addr = '0; req_data = '0; req_op = '0;
    mem_wready = 1'b1;
    req_valid2 = 1'b0; req_addr2 = '0; req_data2 = '0; req_op2 = '0;
    sawWvalid2 = 1'b0;
    checks = 0;
    failures = 0;
    test_reset();
    test_byte();
    test_half();
    test_undef_op();
    test_split_word();
    test_split_half();
    test_wrap();
    test_stall();
    test_reset_mid();
    test_reject();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
